// File: rtl/uart_tx_queue.sv
// Byte queue that feeds the UART transmitter's start/data/done handshake from a circular buffer.
// Optional macro UART_TXQ_OVF_COUNT_EN adds a saturating counter of dropped writes on ovf_count.
module uart_tx_queue #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic              busy,
   output logic [7:0]        ovf_count
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      GAP
   } state_t;

   state_t            state;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   level_next;
   logic              accept;
   logic              drop;
   logic              pop;

   // Full is sampled as registered at the start of the cycle, so a pop cannot make room for a same-cycle write.
   assign accept = wr_en && !full;
   assign drop   = wr_en && full;
   assign pop    = (state == IDLE) && !empty;

   always_comb begin
      level_next = level;
      if (accept && !pop) begin
         level_next = level + 1'b1;
      end else if (pop && !accept) begin
         level_next = level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Status flags are registered from the next level so they always agree with level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         level    <= level_next;
         full     <= (level_next == FULL_LEVEL);
         empty    <= (level_next == '0);
         overflow <= drop;
      end
   end

   // GAP guarantees at least one idle cycle between tx_done and the next launch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  tx_data  <= mem[rd_ptr];
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
                  state    <= LAUNCH;
               end
            end
            LAUNCH: begin
               state <= WAIT;
            end
            WAIT: begin
               if (tx_done) begin
                  busy  <= 1'b0;
                  state <= GAP;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef UART_TXQ_OVF_COUNT_EN
   logic [7:0] ovf_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt <= 8'h00;
      end else if (drop && (ovf_cnt != 8'hFF)) begin
         ovf_cnt <= ovf_cnt + 8'd1;
      end
   end

   assign ovf_count = ovf_cnt;
`else
   assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a queue-based reference model predicts level, launches and drops.
// Honours UART_TXQ_OVF_COUNT_EN when predicting ovf_count.
module tb_uart_tx_queue;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int LW     = ADDR_W + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          tx_done;
   logic          full;
   logic          empty;
   logic [LW-1:0] level;
   logic          overflow;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          busy;
   logic [7:0]    ovf_count;

   int total = 0;
   int bad   = 0;

   // Reference model: byte queue plus the launch/done timing rules of the transmitter handshake.
   logic [7:0] mq[$];
   bit         m_fly;
   int         m_launch;
   int         m_ready;
   int         m_cyc;
   logic [7:0] m_data;
   logic [7:0] m_cnt;
   bit         m_start;
   bit         m_ovf;

   always #5 clk = ~clk;

   uart_tx_queue #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .overflow  (overflow),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_done   (tx_done),
      .busy      (busy),
      .ovf_count (ovf_count)
   );

   function automatic logic [7:0] exp_cnt();
`ifdef UART_TXQ_OVF_COUNT_EN
      return m_cnt;
`else
      return 8'h00;
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      m_fly    = 1'b0;
      m_launch = 0;
      m_ready  = 0;
      m_cyc    = 0;
      m_data   = 8'h00;
      m_cnt    = 8'h00;
      m_start  = 1'b0;
      m_ovf    = 1'b0;
   endtask

   // A launch needs a free transmitter, a non-empty queue and two cycles past the last done.
   task automatic model_step(input logic w, input logic [7:0] d, input logic dn);
      bit was_full;
      bit was_empty;
      bit do_pop;
      bit do_fin;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      do_pop    = !m_fly && (m_cyc >= m_ready) && !was_empty;
      do_fin    = m_fly && dn && (m_cyc >= m_launch + 2);
      m_start   = 1'b0;
      m_ovf     = 1'b0;
      if (do_pop) begin
         m_data   = mq.pop_front();
         m_fly    = 1'b1;
         m_launch = m_cyc;
         m_start  = 1'b1;
      end
      if (w) begin
         if (was_full) begin
            m_ovf = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
         end else begin
            mq.push_back(d);
         end
      end
      if (do_fin) begin
         m_fly   = 1'b0;
         m_ready = m_cyc + 2;
      end
      m_cyc++;
   endtask

   task automatic step(input logic w, input logic [7:0] d, input logic dn);
      wr_en   = w;
      wr_data = d;
      tx_done = dn;
      @(posedge clk);
      model_step(w, d, dn);
      #1;
   endtask

   task automatic do_reset();
      wr_en   = 1'b0;
      wr_data = 8'h00;
      tx_done = 1'b0;
      rst_n   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (level !== '0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", level); end
      total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b want=0", full); end
      total++; if (tx_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_start got=%b want=0", tx_start); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx_data got=%h want=00", tx_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b want=0", overflow); end
      total++; if (ovf_count !== 8'h00) begin bad++; $display("[TB] FAIL reset_ovf_count got=%h want=00", ovf_count); end
   endtask

   task automatic test_single_byte();
      int cnt;
      do_reset();
      step(1'b1, 8'hA5, 1'b0);
      cnt = 1;
      total++; if (empty !== 1'b0) begin bad++; $display("[TB] FAIL single_empty_fall got=%b want=0", empty); end
      while (tx_start !== 1'b1 && cnt < 12) begin
         step(1'b0, 8'h00, 1'b0);
         cnt++;
      end
      total++; if (cnt != 2) begin bad++; $display("[TB] FAIL single_latency got=%0d want=2", cnt); end
      total++; if (tx_data !== 8'hA5) begin bad++; $display("[TB] FAIL single_data got=%h want=a5", tx_data); end
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 8'h00, (i == 20));
         total++; if (busy !== m_fly) begin bad++; $display("[TB] FAIL single_busy cyc=%0d got=%b want=%b", i, busy, m_fly); end
         total++; if (tx_data !== 8'hA5) begin bad++; $display("[TB] FAIL single_hold cyc=%0d got=%h want=a5", i, tx_data); end
         total++; if (tx_start !== 1'b0) begin bad++; $display("[TB] FAIL single_start_once cyc=%0d got=%b want=0", i, tx_start); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_end got=%b want=0", busy); end
      total++; if (level !== '0) begin bad++; $display("[TB] FAIL single_level_end got=%0d want=0", level); end
      total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL single_empty_end got=%b want=1", empty); end
   endtask

   task automatic test_fill_full();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 8'(i), 1'b0);
         total++; if (level !== LW'(mq.size())) begin bad++; $display("[TB] FAIL fill_level i=%0d got=%0d want=%0d", i, level, mq.size()); end
         total++; if (full !== (mq.size() == DEPTH)) begin bad++; $display("[TB] FAIL fill_full i=%0d got=%b want=%b", i, full, (mq.size() == DEPTH)); end
      end
      total++; if (level !== LW'(16)) begin bad++; $display("[TB] FAIL fill_peak got=%0d want=16", level); end
      total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL fill_full_set got=%b want=1", full); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL fill_first_launch got=%h want=00", tx_data); end
      total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL fill_no_ovf got=%b want=0", overflow); end
      step(1'b1, 8'hFF, 1'b0);
      total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_pulse got=%b want=1", overflow); end
      total++; if (level !== LW'(16)) begin bad++; $display("[TB] FAIL ovf_level got=%0d want=16", level); end
      step(1'b0, 8'h00, 1'b0);
      total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_one_cycle got=%b want=0", overflow); end
      total++; if (ovf_count !== exp_cnt()) begin bad++; $display("[TB] FAIL ovf_count got=%h want=%h", ovf_count, exp_cnt()); end
   endtask

   // Continues from the full state left by test_fill_full.
   task automatic test_drain_order();
      int cnt;
      for (int i = 0; i < 17; i++) begin
         total++; if (tx_data !== 8'(i)) begin bad++; $display("[TB] FAIL drain_order i=%0d got=%h want=%h", i, tx_data, 8'(i)); end
         total++; if (level !== LW'(mq.size())) begin bad++; $display("[TB] FAIL drain_level i=%0d got=%0d want=%0d", i, level, mq.size()); end
         if (i > 0) begin
            step(1'b0, 8'h00, ($urandom_range(0, 1) == 1));
            total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL drain_done_in_launch i=%0d got=%b want=1", i, busy); end
         end
         repeat ($urandom_range(0, 4)) step(1'b0, 8'h00, 1'b0);
         step(1'b0, 8'h00, 1'b1);
         total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drain_busy_clear i=%0d got=%b want=0", i, busy); end
         if (i < 16) begin
            cnt = 1;
            while (tx_start !== 1'b1 && cnt < 10) begin
               step(1'b0, 8'h00, 1'b0);
               cnt++;
            end
            total++; if (cnt != 3) begin bad++; $display("[TB] FAIL drain_gap i=%0d got=%0d want=3", i, cnt); end
         end
      end
      step(1'b0, 8'h00, 1'b0);
      total++; if (level !== '0) begin bad++; $display("[TB] FAIL drain_level_end got=%0d want=0", level); end
      total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty_end got=%b want=1", empty); end
      total++; if (tx_start !== 1'b0) begin bad++; $display("[TB] FAIL drain_no_extra got=%b want=0", tx_start); end
   endtask

   task automatic test_wrap();
      logic [7:0] sb[$];
      logic [7:0] d;
      logic [7:0] want;
      logic       w;
      logic       dn;
      int         wcount;
      int         launched;
      int         cyc;
      do_reset();
      wcount   = 0;
      launched = 0;
      cyc      = 0;
      while (launched < 40 && cyc < 3000) begin
         w  = (wcount < 40) && (mq.size() < 10) && ($urandom_range(0, 1) == 1);
         dn = ((mq.size() > 3) || (wcount == 40)) && ($urandom_range(0, 2) == 0);
         d  = 8'($urandom);
         step(w, d, dn);
         if (w) begin
            sb.push_back(d);
            wcount++;
         end
         total++; if (level !== LW'(mq.size())) begin bad++; $display("[TB] FAIL wrap_level cyc=%0d got=%0d want=%0d", cyc, level, mq.size()); end
         total++; if (tx_start !== m_start) begin bad++; $display("[TB] FAIL wrap_start cyc=%0d got=%b want=%b", cyc, tx_start, m_start); end
         if (tx_start === 1'b1) begin
            launched++;
            want = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            total++; if (tx_data !== want) begin bad++; $display("[TB] FAIL wrap_data n=%0d got=%h want=%h", launched, tx_data, want); end
         end
         cyc++;
      end
      total++; if (launched != 40) begin bad++; $display("[TB] FAIL wrap_count got=%0d want=40", launched); end
   endtask

   task automatic test_simultaneous();
      int guard;
      do_reset();
      step(1'b1, 8'h11, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b1, 8'h20 + 8'(k), 1'b0);
      total++; if (level !== LW'(5)) begin bad++; $display("[TB] FAIL simul_pre_level got=%0d want=5", level); end
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h30, 1'b0);
      total++; if (tx_start !== 1'b1) begin bad++; $display("[TB] FAIL simul_pop got=%b want=1", tx_start); end
      total++; if (level !== LW'(5)) begin bad++; $display("[TB] FAIL simul_level got=%0d want=5", level); end
      total++; if (tx_data !== 8'h20) begin bad++; $display("[TB] FAIL simul_data got=%h want=20", tx_data); end
      guard = 0;
      while (mq.size() < DEPTH && guard < 20) begin
         step(1'b1, 8'h60 + 8'(guard), 1'b0);
         guard++;
      end
      total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL simul_full got=%b want=1", full); end
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'hEE, 1'b0);
      total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL simul_full_drop got=%b want=1", overflow); end
      total++; if (tx_start !== 1'b1) begin bad++; $display("[TB] FAIL simul_full_pop got=%b want=1", tx_start); end
      total++; if (level !== LW'(15)) begin bad++; $display("[TB] FAIL simul_full_level got=%0d want=15", level); end
      total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL simul_full_clear got=%b want=0", full); end
      step(1'b0, 8'h00, 1'b0);
      total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL simul_ovf_once got=%b want=0", overflow); end
      total++; if (ovf_count !== exp_cnt()) begin bad++; $display("[TB] FAIL simul_ovf_count got=%h want=%h", ovf_count, exp_cnt()); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 8; k++) step(1'b1, 8'h40 + 8'(k), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_busy got=%b want=1", busy); end
      total++; if (level !== LW'(7)) begin bad++; $display("[TB] FAIL mid_pre_level got=%0d want=7", level); end
      rst_n = 1'b0;
      #2;
      total++; if (level !== '0) begin bad++; $display("[TB] FAIL mid_level got=%0d want=0", level); end
      total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL mid_empty got=%b want=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL mid_full got=%b want=0", full); end
      total++; if (tx_start !== 1'b0) begin bad++; $display("[TB] FAIL mid_tx_start got=%b want=0", tx_start); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL mid_tx_data got=%h want=00", tx_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b want=0", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL mid_overflow got=%b want=0", overflow); end
      total++; if (ovf_count !== 8'h00) begin bad++; $display("[TB] FAIL mid_ovf_count got=%h want=00", ovf_count); end
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 8'h00, ($urandom_range(0, 1) == 1));
         total++; if (tx_start !== 1'b0) begin bad++; $display("[TB] FAIL mid_no_relaunch cyc=%0d got=%b want=0", i, tx_start); end
         total++; if (level !== '0) begin bad++; $display("[TB] FAIL mid_flushed cyc=%0d got=%0d want=0", i, level); end
      end
      step(1'b1, 8'h5A, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      total++; if (tx_start !== 1'b1) begin bad++; $display("[TB] FAIL mid_new_start got=%b want=1", tx_start); end
      total++; if (tx_data !== 8'h5A) begin bad++; $display("[TB] FAIL mid_new_data got=%h want=5a", tx_data); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      tx_done = 1'b0;
      $display("[TB] starting uart_tx_queue bench");
      test_reset();
      test_single_byte();
      test_fill_full();
      test_drain_order();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
